// File: rtl/dmem_store_buffer_resp_pkg.sv
// Shared types for the MEM-stage load/store responder: funct3 codes, store-buffer entry, drain FSM states.
// Optional feature macro: DMEM_STORE_FWD_EN (store-to-load forwarding).
package dmem_store_buffer_resp_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int BYTES      = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        F3_LB  = 3'd0,
        F3_LH  = 3'd1,
        F3_LW  = 3'd2,
        F3_LBU = 3'd4,
        F3_LHU = 3'd5
    } load_f3_e;

    typedef enum logic [2:0] {
        F3_SB = 3'd0,
        F3_SH = 3'd1,
        F3_SW = 3'd2
    } store_f3_e;

    typedef struct packed {
        logic [DATA_WIDTH-3:0] waddr;
        logic [BYTES-1:0]      be;
        logic [DATA_WIDTH-1:0] data;
    } sb_entry_t;

    typedef enum logic [1:0] {
        DR_IDLE,
        DR_READ,
        DR_MERGE,
        DR_WRITE
    } drain_state_e;

    // funct3[1:0] is 1 for halfwords and 2 for words, for loads and stores alike
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'd1:    return a[0];
            2'd2:    return a != 2'd0;
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/dmem_store_buffer_resp_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
interface dmem_store_buffer_resp_if;
    import dmem_store_buffer_resp_pkg::*;

    logic                  req_valid_i;
    logic                  req_write_i;
    logic [2:0]            req_funct3_i;
    logic [DATA_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  req_ready_o;
    logic                  rsp_valid_o;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_misalign_o;
    logic                  sb_empty_o;

    modport master (
        output req_valid_i, req_write_i, req_funct3_i, req_addr_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_misalign_o, sb_empty_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_funct3_i, req_addr_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_misalign_o, sb_empty_o
    );
endinterface

// File: rtl/dmem_sp_ram.sv
// Word-wide single-port RAM: synchronous write, registered read (read data holds until the next read).
module dmem_sp_ram
    import dmem_store_buffer_resp_pkg::*;
#(
    parameter  int MEM_WORDS = 1024,
    parameter  int DW        = DATA_WIDTH,
    localparam int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_q [MEM_WORDS];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en && we)
            mem_q[addr] <= wdata;
        else if (en)
            rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/dmem_store_buffer_resp.sv
// Data-memory responder: in-order store buffer drained into a single-port RAM, loads answered next cycle.
// DMEM_STORE_FWD_EN: loads merge matching buffered stores; otherwise such loads stall until drained.
module dmem_store_buffer_resp
    import dmem_store_buffer_resp_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int SB_DEPTH  = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    dmem_store_buffer_resp_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int WW = DATA_WIDTH - 2;

    sb_entry_t             sb_q [SB_DEPTH];
    sb_entry_t             sb_d [SB_DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [PW:0]           cnt_q, cnt_d;
    drain_state_e          st_q, st_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_load_q, rsp_load_d, rsp_mis_q, rsp_mis_d;
    logic [2:0]            rsp_f3_q, rsp_f3_d;
    logic [1:0]            rsp_lane_q, rsp_lane_d;
    logic [BYTES-1:0]      fwd_be_q, fwd_be_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

    logic [WW-1:0]         req_waddr;
    logic [1:0]            req_lane;
    logic [BYTES-1:0]      req_be;
    logic                  req_mis, ready, fire, load_fire, push, pop;
    sb_entry_t             head;
    logic                  ram_en, ram_we;
    logic [AW-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata, ld_word, ld_shift, ld_ext;
    logic                  unused_bits;
`ifndef DMEM_STORE_FWD_EN
    logic                  sb_hit;
`endif

    assign req_waddr   = WW'(bus.req_addr_i[AW+1:2]);
    assign req_lane    = bus.req_addr_i[1:0];
    assign req_mis     = is_misaligned(bus.req_funct3_i, req_lane);
    assign head        = sb_q[head_q];
    assign unused_bits = ^{bus.req_addr_i[DATA_WIDTH-1:AW+2], head.waddr[WW-1:AW]};

    // Walk live entries oldest to youngest so younger bytes overwrite older ones.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_be_d   = '0;
        fwd_data_d = '0;
`ifndef DMEM_STORE_FWD_EN
        sb_hit     = 1'b0;
`endif
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (((PW+1)'(i) < cnt_q) && (sb_q[idx].waddr == req_waddr)) begin
`ifdef DMEM_STORE_FWD_EN
                for (int b = 0; b < BYTES; b++) begin
                    if (sb_q[idx].be[b]) begin
                        fwd_be_d[b]         = 1'b1;
                        fwd_data_d[8*b +: 8] = sb_q[idx].data[8*b +: 8];
                    end
                end
`else
                sb_hit = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        case (bus.req_funct3_i[1:0])
            2'd0:    req_be = 4'b0001 << req_lane;
            2'd1:    req_be = 4'b0011 << req_lane;
            default: req_be = 4'b1111;
        endcase

        // Pre-pop occupancy only: a pop this cycle must not reach ready combinationally.
        if (bus.req_write_i)
            ready = (cnt_q != (PW+1)'(SB_DEPTH));
`ifdef DMEM_STORE_FWD_EN
        else
            ready = 1'b1;
`else
        else
            ready = req_mis || !sb_hit;
`endif

        fire      = bus.req_valid_i && ready;
        load_fire = fire && !bus.req_write_i && !req_mis;
        push      = fire && bus.req_write_i && !req_mis;

        pop      = 1'b0;
        ram_en   = load_fire;
        ram_we   = 1'b0;
        ram_addr = req_waddr[AW-1:0];
        st_d     = st_q;
        word_d   = word_q;

        // A load owns the RAM port; READ and WRITE simply retry next cycle.
        case (st_q)
            DR_IDLE: begin
                if (cnt_q != '0) begin
                    if (head.be == '1) begin
                        st_d   = DR_WRITE;
                        word_d = head.data;
                    end else begin
                        st_d = DR_READ;
                    end
                end
            end
            DR_READ: begin
                if (!load_fire) begin
                    ram_en   = 1'b1;
                    ram_addr = head.waddr[AW-1:0];
                    st_d     = DR_MERGE;
                end
            end
            DR_MERGE: begin
                for (int b = 0; b < BYTES; b++)
                    word_d[8*b +: 8] = head.be[b] ? head.data[8*b +: 8] : ram_rdata[8*b +: 8];
                st_d = DR_WRITE;
            end
            DR_WRITE: begin
                if (!load_fire) begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = head.waddr[AW-1:0];
                    pop      = 1'b1;
                    st_d     = DR_IDLE;
                end
            end
            default: st_d = DR_IDLE;
        endcase

        sb_d   = sb_q;
        tail_d = tail_q;
        if (push) begin
            sb_d[tail_q] = '{waddr: req_waddr, be: req_be, data: bus.req_wdata_i << {req_lane, 3'b000}};
            tail_d       = tail_q + PW'(1);
        end
        head_d = pop ? head_q + PW'(1) : head_q;
        cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(pop);

        rsp_valid_d = fire;
        rsp_load_d  = fire && !bus.req_write_i;
        rsp_mis_d   = fire && req_mis;
        rsp_f3_d    = bus.req_funct3_i;
        rsp_lane_d  = req_lane;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SB_DEPTH; i++) sb_q[i] <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            st_q        <= DR_IDLE;
            word_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_load_q  <= 1'b0;
            rsp_mis_q   <= 1'b0;
            rsp_f3_q    <= '0;
            rsp_lane_q  <= '0;
            fwd_be_q    <= '0;
            fwd_data_q  <= '0;
        end else begin
            sb_q        <= sb_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            st_q        <= st_d;
            word_q      <= word_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_load_q  <= rsp_load_d;
            rsp_mis_q   <= rsp_mis_d;
            rsp_f3_q    <= rsp_f3_d;
            rsp_lane_q  <= rsp_lane_d;
            fwd_be_q    <= fwd_be_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    dmem_sp_ram #(.MEM_WORDS(MEM_WORDS), .DW(DATA_WIDTH)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (word_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        for (int b = 0; b < BYTES; b++)
            ld_word[8*b +: 8] = fwd_be_q[b] ? fwd_data_q[8*b +: 8] : ram_rdata[8*b +: 8];
        ld_shift = ld_word >> {rsp_lane_q, 3'b000};
        case (rsp_f3_q)
            F3_LB:   ld_ext = {{(DATA_WIDTH-8){ld_shift[7]}}, ld_shift[7:0]};
            F3_LH:   ld_ext = {{(DATA_WIDTH-16){ld_shift[15]}}, ld_shift[15:0]};
            F3_LBU:  ld_ext = {{(DATA_WIDTH-8){1'b0}}, ld_shift[7:0]};
            F3_LHU:  ld_ext = {{(DATA_WIDTH-16){1'b0}}, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    assign bus.req_ready_o    = ready;
    assign bus.rsp_valid_o    = rsp_valid_q;
    assign bus.rsp_misalign_o = rsp_mis_q;
    assign bus.rsp_rdata_o    = (rsp_valid_q && rsp_load_q && !rsp_mis_q) ? ld_ext : '0;
    assign bus.sb_empty_o     = (cnt_q == '0) && (st_q == DR_IDLE);
endmodule

// File: tb/tb_dmem_store_buffer_resp.sv
// Directed bench for dmem_store_buffer_resp: forwarding/stall, extension, misalign, full buffer, drain preemption, reset.
module tb_dmem_store_buffer_resp;
    import dmem_store_buffer_resp_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dmem_store_buffer_resp_if bus();

    dmem_store_buffer_resp #(.MEM_WORDS(1024), .SB_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; returns on the falling edge after acceptance with the response sampled.
    task automatic req(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic mis, output int waits);
        bus.req_valid_i  = 1'b1;
        bus.req_write_i  = wr;
        bus.req_funct3_i = f3;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wd;
        waits = 0;
        rd    = '0;
        mis   = 1'b0;
        #1;
        while (!bus.req_ready_o && waits < 40) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!bus.req_ready_o) begin
            chk("req_ready_timeout", 32'(bus.req_ready_o), 32'd1);
            bus.req_valid_i = 1'b0;
            @(negedge clk);
            return;
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        chk("rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
        rd  = bus.rsp_rdata_o;
        mis = bus.rsp_misalign_o;
    endtask

    task automatic wait_empty(input string tag);
        int k = 0;
        while (!bus.sb_empty_o && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(bus.sb_empty_o), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        mis;
        int          w;

        bus.req_valid_i  = 1'b0;
        bus.req_write_i  = 1'b0;
        bus.req_funct3_i = '0;
        bus.req_addr_i   = '0;
        bus.req_wdata_i  = '0;
        repeat (2) @(negedge clk);
        chk("rst_sb_empty", 32'(bus.sb_empty_o), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata_o, 32'd0);
        chk("rst_rsp_misalign", 32'(bus.rsp_misalign_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // store then immediate load of the same word
        req(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, rd, mis, w);
        chk("sw_rdata_zero", rd, 32'd0);
        req(1'b0, 3'd2, 32'h100, 32'h0, rd, mis, w);
        chk("lw_after_sw", rd, 32'hDEADBEEF);
`ifdef DMEM_STORE_FWD_EN
        chk("lw_fwd_no_stall", 32'(w), 32'd0);
`else
        chk("lw_hazard_stall", 32'(w != 0), 32'd1);
`endif
        @(negedge clk);
        chk("rsp_one_cycle_pulse", 32'(bus.rsp_valid_o), 32'd0);

        // word + byte store into the same word, then extended loads
        req(1'b1, 3'd2, 32'h200, 32'h11223344, rd, mis, w);
        req(1'b1, 3'd0, 32'h201, 32'h000000AA, rd, mis, w);
        req(1'b0, 3'd4, 32'h201, 32'h0, rd, mis, w);
        chk("lbu_201", rd, 32'h000000AA);
        req(1'b0, 3'd0, 32'h201, 32'h0, rd, mis, w);
        chk("lb_201", rd, 32'hFFFFFFAA);
        req(1'b0, 3'd2, 32'h200, 32'h0, rd, mis, w);
        chk("lw_200_merged", rd, 32'h1122AA44);

        // misaligned load and store
        req(1'b0, 3'd1, 32'h203, 32'h0, rd, mis, w);
        chk("lh_203_misalign", 32'(mis), 32'd1);
        chk("lh_203_rdata", rd, 32'd0);
        req(1'b1, 3'd2, 32'h102, 32'h55555555, rd, mis, w);
        chk("sw_102_misalign", 32'(mis), 32'd1);
        wait_empty("empty_after_misalign");
        req(1'b0, 3'd2, 32'h100, 32'h0, rd, mis, w);
        chk("lw_100_unchanged", rd, 32'hDEADBEEF);
        chk("lw_100_aligned", 32'(mis), 32'd0);

        // fill the buffer with byte stores, fifth store must wait for a pop
        req(1'b1, 3'd0, 32'h400, 32'h11, rd, mis, w);
        req(1'b1, 3'd0, 32'h404, 32'h22, rd, mis, w);
        req(1'b1, 3'd0, 32'h408, 32'h33, rd, mis, w);
        req(1'b1, 3'd0, 32'h40C, 32'h44, rd, mis, w);
        req(1'b1, 3'd0, 32'h410, 32'h55, rd, mis, w);
        chk("full_wait_1to3", 32'(w >= 1 && w <= 3), 32'd1);
        wait_empty("empty_after_full");
        req(1'b0, 3'd4, 32'h40C, 32'h0, rd, mis, w);
        chk("lbu_40c", rd, 32'h00000044);
        req(1'b0, 3'd4, 32'h410, 32'h0, rd, mis, w);
        chk("lbu_410", rd, 32'h00000055);

        // halfword store held in READ by a stream of unrelated loads
        req(1'b1, 3'd1, 32'h300, 32'h0000BEEF, rd, mis, w);
        repeat (5) req(1'b0, 3'd2, 32'h500, 32'h0, rd, mis, w);
        chk("drain_preempted", 32'(bus.sb_empty_o), 32'd0);
        req(1'b0, 3'd5, 32'h300, 32'h0, rd, mis, w);
        chk("lhu_300", rd, 32'h0000BEEF);

        // reset with three partial stores in flight
        wait_empty("empty_before_reset");
        req(1'b1, 3'd2, 32'h600, 32'h0, rd, mis, w);
        req(1'b1, 3'd2, 32'h604, 32'h0, rd, mis, w);
        req(1'b1, 3'd2, 32'h608, 32'h0, rd, mis, w);
        wait_empty("empty_after_zero_fill");
        req(1'b1, 3'd0, 32'h600, 32'hA1, rd, mis, w);
        req(1'b1, 3'd0, 32'h604, 32'hA2, rd, mis, w);
        req(1'b1, 3'd0, 32'h608, 32'hA3, rd, mis, w);
        chk("pre_reset_not_empty", 32'(bus.sb_empty_o), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_sb_empty", 32'(bus.sb_empty_o), 32'd1);
        chk("mid_reset_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_empty", 32'(bus.sb_empty_o), 32'd1);
        req(1'b0, 3'd2, 32'h600, 32'h0, rd, mis, w);
        chk("lw_600_no_write", rd, 32'd0);
        req(1'b0, 3'd2, 32'h604, 32'h0, rd, mis, w);
        chk("lw_604_no_write", rd, 32'd0);
        req(1'b0, 3'd2, 32'h608, 32'h0, rd, mis, w);
        chk("lw_608_no_write", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
